// File: rtl/processor_pkg.sv
// processor_pkg: constants and types shared by the fetch stage and its stack.
//   ADR_W / INSTR_W        : default address and instruction widths
//   NOP_WORD               : word placed in IR on squash, flush or reset
//   RESET_VECTOR           : first fetch address after reset
//   INT_VECTOR             : interrupt service entry address
//   redirect_e             : which PC redirect wins in a given cycle
//   redirect_sel()         : priority resolver for the redirect sources
package processor_pkg;

    localparam int              ADR_W        = 12;
    localparam int              INSTR_W      = 16;
    localparam logic [15:0]     NOP_WORD     = 16'h0000;
    localparam logic [11:0]     RESET_VECTOR = 12'h000;
    localparam logic [11:0]     INT_VECTOR   = 12'h004;

    typedef enum logic [2:0] {
        RD_NONE,
        RD_INT,
        RD_RTI,
        RD_RET,
        RD_CALL,
        RD_BR
    } redirect_e;

    // Highest-priority active source wins; the rest are discarded outright.
    function automatic redirect_e redirect_sel(input logic intr, input logic rti,
                                               input logic ret, input logic call,
                                               input logic br);
        redirect_e sel;
        sel = RD_NONE;
        if (intr)      sel = RD_INT;
        else if (rti)  sel = RD_RTI;
        else if (ret)  sel = RD_RET;
        else if (call) sel = RD_CALL;
        else if (br)   sel = RD_BR;
        return sel;
    endfunction

endpackage

// File: rtl/return_address_stack.sv
// return_address_stack: LIFO of return addresses for subroutine call/return.
//   i_clk, i_rst      : clock, async active-high reset (empties the stack)
//   i_push, i_din     : push i_din (dropped when full, sets o_overflow)
//   i_pop             : pop top entry (ignored when empty, sets o_underflow)
//   o_top             : raw top entry; only meaningful when !o_empty
//   o_full, o_empty   : occupancy status
//   o_overflow/o_underflow : sticky error flags, cleared only by reset
module return_address_stack
    import processor_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = ADR_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_top,
    output logic         o_full,
    output logic         o_empty,
    output logic         o_overflow,
    output logic         o_underflow
);

    localparam int IW  = $clog2(DEPTH);
    localparam int SPW = IW + 1;

    logic [W-1:0]   r_mem [DEPTH];
    logic [SPW-1:0] r_sp;        // 0..DEPTH entries in use
    logic [IW-1:0]  w_wr_idx;
    logic [IW-1:0]  w_top_idx;

    assign o_full    = (r_sp == SPW'(DEPTH));
    assign o_empty   = (r_sp == '0);
    assign w_wr_idx  = r_sp[IW-1:0];
    // Wraps to DEPTH-1 when empty; callers mask with o_empty.
    assign w_top_idx = w_wr_idx - IW'(1);
    assign o_top     = r_mem[w_top_idx];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sp        <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_push) begin
            if (o_full) begin
                o_overflow <= 1'b1;
            end else begin
                r_mem[w_wr_idx] <= i_din;
                r_sp            <= r_sp + SPW'(1);
            end
        end else if (i_pop) begin
            if (o_empty) o_underflow <= 1'b1;
            else         r_sp        <= r_sp - SPW'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding decode.
//   clk, reset            : clock, async active-high reset
//   imem_adr / imem_data  : instruction memory address (fetch PC) and same-cycle data
//   stall_f, flush_f      : hold all state / squash the word being fetched
//   branch_*, subroutine_*, call_*, irq, IEN, IOF, RTI : redirect and interrupt controls
//   IR, PC                : registered instruction and its address, to decode
//   RTS_adr               : top of return stack (0 when empty)
//   int_enable            : interrupt-enable state
//   ras_overflow/underflow: sticky stack error flags
module fetch_unit #(
    parameter int                ADR_W        = processor_pkg::ADR_W,
    parameter int                INSTR_W      = processor_pkg::INSTR_W,
    parameter int                RAS_DEPTH    = 8,
    parameter logic [ADR_W-1:0]  RESET_VECTOR = processor_pkg::RESET_VECTOR,
    parameter logic [ADR_W-1:0]  INT_VECTOR   = processor_pkg::INT_VECTOR,
    parameter logic [INSTR_W-1:0] NOP_WORD    = processor_pkg::NOP_WORD
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADR_W-1:0]   imem_adr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               stall_f,
    input  logic               flush_f,
    input  logic               branch_taken,
    input  logic [ADR_W-1:0]   branch_target,
    input  logic               subroutine_call,
    input  logic [ADR_W-1:0]   call_target,
    input  logic [ADR_W-1:0]   call_return_adr,
    input  logic               subroutine_return,
    input  logic               irq,
    input  logic               IEN,
    input  logic               IOF,
    input  logic               RTI,
    output logic [INSTR_W-1:0] IR,
    output logic [ADR_W-1:0]   PC,
    output logic [ADR_W-1:0]   RTS_adr,
    output logic               int_enable,
    output logic               ras_overflow,
    output logic               ras_underflow
);

    import processor_pkg::*;

    logic [ADR_W-1:0] r_fpc;
    logic [ADR_W-1:0] r_epc;
    redirect_e        w_sel;
    logic [ADR_W-1:0] w_next_fpc;
    logic             w_push;
    logic             w_pop;
    logic [ADR_W-1:0] w_ras_top;
    logic             w_ras_full;
    logic             w_ras_empty;

    assign imem_adr = r_fpc;
    assign RTS_adr  = w_ras_empty ? '0 : w_ras_top;

    // Stall gates the stack too, so it never sees a push/pop while held.
    always_comb begin
        w_sel      = redirect_sel(irq & int_enable, RTI, subroutine_return,
                                  subroutine_call, branch_taken);
        w_next_fpc = r_fpc + ADR_W'(1);
        w_push     = 1'b0;
        w_pop      = 1'b0;
        case (w_sel)
            RD_INT:  w_next_fpc = INT_VECTOR;
            RD_RTI:  w_next_fpc = r_epc;
            RD_RET:  begin w_next_fpc = RTS_adr;     w_pop  = ~stall_f; end
            RD_CALL: begin w_next_fpc = call_target; w_push = ~stall_f; end
            RD_BR:   w_next_fpc = branch_target;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fpc      <= RESET_VECTOR;
            r_epc      <= '0;
            IR         <= NOP_WORD;
            PC         <= '0;
            int_enable <= 1'b0;
        end else if (!stall_f) begin
            r_fpc <= w_next_fpc;
            PC    <= r_fpc;   // squashed fetches still report their address
            IR    <= (w_sel != RD_NONE || flush_f) ? NOP_WORD : imem_data;
            case (w_sel)
                RD_INT: begin r_epc <= r_fpc; int_enable <= 1'b0; end
                RD_RTI: int_enable <= 1'b1;
                default: begin
                    if (IOF)      int_enable <= 1'b0;
                    else if (IEN) int_enable <= 1'b1;
                end
            endcase
        end
    end

    return_address_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (ADR_W)
    ) u_ras (
        .i_clk       (clk),
        .i_rst       (reset),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_din       (call_return_adr),
        .o_top       (w_ras_top),
        .o_full      (w_ras_full),
        .o_empty     (w_ras_empty),
        .o_overflow  (ras_overflow),
        .o_underflow (ras_underflow)
    );

    // A push into a full stack must always leave the overflow flag raised.
    a_ovf: assert property (@(posedge clk) disable iff (reset)
                            (w_push && w_ras_full) |=> ras_overflow);

endmodule
